// File: rtl/midi_pkg.sv
// Shared MIDI definitions: receiver state encoding, bit rate and status constants.
package midi_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  localparam int         MIDI_BAUD    = 31250;
  localparam logic [7:0] NOTE_ON      = 8'h90;
  localparam logic [7:0] NOTE_OFF     = 8'h80;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  function automatic logic isRealtime(input logic [7:0] data);
    return data >= REALTIME_MIN;
  endfunction

endpackage

// File: rtl/midi_rx_sync.sv
// Two-flop synchronizer for the raw MIDI line; resets to the idle (high) level.
module midi_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1 framing, mid-bit sampling, optional real-time byte filter.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int BAUD            = MIDI_BAUD,
  parameter bit FILTER_REALTIME = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] new_byte,
  output logic       new_byte_ready,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMER_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);

  logic               w_rx;
  rxState_t           r_state;
  rxState_t           w_nextState;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_bitCnt;
  logic [7:0]         r_shift;
  logic               r_waitHigh;
  logic [7:0]         r_newByte;
  logic               r_ready;
  logic               r_frameErr;

  logic w_timerDone;
  logic w_clearTimer;
  logic w_shiftEn;
  logic w_accept;
  logic w_frameErr;
  logic w_publish;

  midi_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (midi_rx),
    .o_sync  (w_rx)
  );

  assign w_timerDone = (r_state == RX_START) ? (r_timer == HALF_LAST)
                                             : (r_timer == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RX_IDLE;
    else        r_state <= w_nextState;
  end

  // After a framing error, IDLE ignores the line until it has been seen high once.
  always_comb begin
    w_nextState  = r_state;
    w_clearTimer = 1'b0;
    w_shiftEn    = 1'b0;
    w_accept     = 1'b0;
    w_frameErr   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (!r_waitHigh && !w_rx) begin
          w_nextState  = RX_START;
          w_clearTimer = 1'b1;
        end
      end
      RX_START: begin
        if (w_timerDone) begin
          w_clearTimer = 1'b1;
          w_nextState  = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_timerDone) begin
          w_clearTimer = 1'b1;
          w_shiftEn    = 1'b1;
          if (r_bitCnt == 3'd7) w_nextState = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_timerDone) begin
          w_clearTimer = 1'b1;
          w_nextState  = RX_IDLE;
          w_accept     = w_rx;
          w_frameErr   = !w_rx;
        end
      end
      default: w_nextState = RX_IDLE;
    endcase
  end

  assign w_publish = w_accept && !(FILTER_REALTIME && isRealtime(r_shift));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer    <= '0;
      r_bitCnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_waitHigh <= 1'b0;
      r_newByte  <= 8'h00;
      r_ready    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_clearTimer || r_state == RX_IDLE) r_timer <= '0;
      else                                    r_timer <= r_timer + 1'b1;

      if (r_state != RX_DATA) r_bitCnt <= 3'd0;
      else if (w_shiftEn)     r_bitCnt <= r_bitCnt + 3'd1;

      if (w_shiftEn) r_shift <= {w_rx, r_shift[7:1]};

      if (w_frameErr)                     r_waitHigh <= 1'b1;
      else if (r_state == RX_IDLE && w_rx) r_waitHigh <= 1'b0;

      if (w_publish) r_newByte <= r_shift;
      r_ready    <= w_publish;
      r_frameErr <= w_frameErr;
    end
  end

  assign new_byte       = r_newByte;
  assign new_byte_ready = r_ready;
  assign framing_error  = r_frameErr;
  assign rx_busy        = (r_state != RX_IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at 16 clocks per bit, with the real-time filter on and off.
module tb_midi_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       rxLine;
  logic [7:0] newByte0, newByte1;
  logic       ready0, ready1;
  logic       frameErr0, frameErr1;
  logic       busy0, busy1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int ferrCnt0, ferrCnt1, bothCnt;

  midi_uart_rx #(.CLK_HZ(1_600_000), .BAUD(100000), .FILTER_REALTIME(1'b1)) dutFilt (
    .clk(clk), .reset(reset), .midi_rx(rxLine),
    .new_byte(newByte0), .new_byte_ready(ready0),
    .framing_error(frameErr0), .rx_busy(busy0)
  );

  midi_uart_rx #(.CLK_HZ(1_600_000), .BAUD(100000), .FILTER_REALTIME(1'b0)) dutRaw (
    .clk(clk), .reset(reset), .midi_rx(rxLine),
    .new_byte(newByte1), .new_byte_ready(ready1),
    .framing_error(frameErr1), .rx_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every pulse on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (ready0) q0.push_back(newByte0);
    if (ready1) q1.push_back(newByte1);
    if (frameErr0) ferrCnt0++;
    if (frameErr1) ferrCnt1++;
    if ((ready0 && frameErr0) || (ready1 && frameErr1)) bothCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] logged0(input int idx);
    return (idx < q0.size()) ? {24'h0, q0[idx]} : 32'hDEAD;
  endfunction

  function automatic logic [31:0] logged1(input int idx);
    return (idx < q1.size()) ? {24'h0, q1[idx]} : 32'hDEAD;
  endfunction

  task automatic clearLog();
    q0.delete();
    q1.delete();
    ferrCnt0 = 0;
    ferrCnt1 = 0;
  endtask

  task automatic driveBit(input logic v);
    rxLine = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    rxLine = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stopBit);
    if (!stopBit) begin
      driveBit(1'b1);
      driveBit(1'b1);
    end
  endtask

  initial begin
    logic [7:0] partial;
    rxLine  = 1'b1;
    bothCnt = 0;
    reset   = 1'b0;
    clearLog();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("reset new_byte", {24'h0, newByte0}, 32'h00);
    checkOutput("reset ready", {31'h0, ready0}, 32'h0);
    checkOutput("reset framing_error", {31'h0, frameErr0}, 32'h0);
    checkOutput("reset rx_busy", {31'h0, busy0}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    idleCycles(5);

    $display("[TB] single frame 0x90");
    clearLog();
    applyStimulus(8'h90, 1'b1);
    idleCycles(20);
    checkOutput("single count", q0.size(), 1);
    checkOutput("single value", logged0(0), 32'h90);
    checkOutput("single new_byte held", {24'h0, newByte0}, 32'h90);
    checkOutput("single no ferr", ferrCnt0, 0);

    $display("[TB] back-to-back 90 3C 7F");
    clearLog();
    applyStimulus(8'h90, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h7F, 1'b1);
    idleCycles(20);
    checkOutput("b2b count", q0.size(), 3);
    checkOutput("b2b byte0", logged0(0), 32'h90);
    checkOutput("b2b byte1", logged0(1), 32'h3C);
    checkOutput("b2b byte2", logged0(2), 32'h7F);

    $display("[TB] framing error on 0x55 then 0x80");
    clearLog();
    applyStimulus(8'h55, 1'b0);
    idleCycles(10);
    checkOutput("ferr count", ferrCnt0, 1);
    checkOutput("ferr no ready", q0.size(), 0);
    checkOutput("ferr new_byte kept", {24'h0, newByte0}, 32'h7F);
    clearLog();
    applyStimulus(8'h80, 1'b1);
    idleCycles(20);
    checkOutput("post-ferr count", q0.size(), 1);
    checkOutput("post-ferr value", logged0(0), 32'h80);
    checkOutput("post-ferr no ferr", ferrCnt0, 0);

    $display("[TB] 4-cycle glitch");
    clearLog();
    rxLine = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("glitch busy rises", {31'h0, busy0}, 32'h1);
    @(posedge clk); #1;
    idleCycles(20);
    checkOutput("glitch busy falls", {31'h0, busy0}, 32'h0);
    checkOutput("glitch no ready", q0.size(), 0);
    checkOutput("glitch no ferr", ferrCnt0, 0);

    $display("[TB] real-time filter F7/F8");
    clearLog();
    applyStimulus(8'hF7, 1'b1);
    applyStimulus(8'hF8, 1'b1);
    idleCycles(20);
    checkOutput("filt count", q0.size(), 1);
    checkOutput("filt F7 passes", logged0(0), 32'hF7);
    checkOutput("filt new_byte kept", {24'h0, newByte0}, 32'hF7);
    checkOutput("raw count", q1.size(), 2);
    checkOutput("raw F8 value", logged1(1), 32'hF8);
    checkOutput("raw new_byte", {24'h0, newByte1}, 32'hF8);

    $display("[TB] reset during data bit 4 of 0x3C");
    clearLog();
    partial = 8'h3C;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(partial[i]);
    rxLine = partial[4];
    repeat (CPB / 2) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-frame busy", {31'h0, busy0}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort new_byte", {24'h0, newByte0}, 32'h00);
    checkOutput("abort ready", {31'h0, ready0}, 32'h0);
    checkOutput("abort ferr", {31'h0, frameErr0}, 32'h0);
    checkOutput("abort busy", {31'h0, busy0}, 32'h0);
    rxLine = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idleCycles(40);
    checkOutput("abort no pulse", q0.size(), 0);
    checkOutput("abort no ferr", ferrCnt0, 0);
    applyStimulus(8'h40, 1'b1);
    idleCycles(20);
    checkOutput("after abort count", q0.size(), 1);
    checkOutput("after abort value", logged0(0), 32'h40);

    checkOutput("ready/ferr exclusive", bothCnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_uart_rx.md
MIDI_UART_RX -- requirements
Module: midi_uart_rx

Interface
REQ-001 The parameter list SHALL be:
- CLK_HZ, default 100_000_000, system clock frequency.
- BAUD, default 31250, MIDI serial bit rate.
- FILTER_REALTIME, default 1, when 1 drop bytes 0xF8-0xFF.

REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- midi_rx  input  1  raw serial MIDI line, idle high, asynchronous to clk.
- new_byte  output  8  last accepted byte, held stable until the next accept.
- new_byte_ready  output  1  one-cycle pulse, new_byte valid in the same cycle.
- framing_error  output  1  one-cycle pulse on a bad stop bit.
- rx_busy  output  1  high while a frame is being received.

REQ-003 The design SHALL have one clock and an asynchronous, active-low reset (port name reset); the polarity and synchronicity are fixed.

Function
REQ-004 midi_rx SHALL pass through a two-flop synchronizer before any use (2-cycle input latency).
REQ-005 CLKS_PER_BIT SHALL equal CLK_HZ/BAUD with integer truncation (3200 at defaults); HALF_BIT SHALL equal CLKS_PER_BIT/2.
REQ-006 The FSM SHALL have four states, IDLE, START, DATA and STOP, with these transitions:
- IDLE: on synchronized rx = 0, go to START and clear the bit timer.
- START: after HALF_BIT cycles, sample rx. If 0, go to DATA. If 1, treat it as a glitch, go to IDLE and produce no output.
- DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx. If 1, accept the byte. If 0, pulse framing_error and go to WAIT_HIGH.
- WAIT_HIGH (a sub-state of IDLE): return to IDLE only after rx has been 1 for one full cycle.
REQ-007 On accept, new_byte SHALL update and new_byte_ready SHALL pulse exactly one cycle, in the cycle after the stop-bit sample.
REQ-008 When FILTER_REALTIME = 1 and the accepted byte is 0xF8 or higher, there SHALL be no new_byte_ready pulse and new_byte SHALL keep its previous value.
REQ-009 new_byte_ready and framing_error SHALL never assert in the same cycle.
REQ-010 rx_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-011 The bit timer SHALL be wide enough for CLKS_PER_BIT-1 with no wrap-around; the bit counter is 3 bits and counts 0 to 7.
REQ-012 A falling edge during STOP or DATA SHALL NOT restart the frame; sampling continues on schedule.
REQ-013 A start edge arriving in the cycle immediately after returning to IDLE SHALL be accepted, so back-to-back frames with one stop bit are received without loss.

Reset
REQ-014 While reset = 0, the block SHALL hold: state IDLE, new_byte = 8'h00, new_byte_ready = 0, framing_error = 0, rx_busy = 0, timers cleared, and both synchronizer flops = 1 (idle line).
REQ-015 Reset asserted mid-frame SHALL abandon the frame immediately with no output pulse; after release, reception restarts on the next falling edge.

Structure
REQ-016 Shared package midi_pkg SHALL hold the rx state enum, MIDI_BAUD = 31250, the status constants NOTE_ON = 8'h90 and NOTE_OFF = 8'h80, and REALTIME_MIN = 8'hF8.
REQ-017 The two-flop synchronizer SHALL be one sub-module, midi_rx_sync, with its reset value set to 1.
REQ-018 new_byte and new_byte_ready SHALL connect directly to the same-named inputs of midi_player.

Verification (benches use CLK_HZ = 1_600_000, BAUD = 100000, giving CLKS_PER_BIT = 16)
REQ-019 Send the frame 0x90 -> exactly one new_byte_ready pulse with new_byte = 8'h90; framing_error stays 0.
REQ-020 Send 0x90, 0x3C, 0x7F back-to-back with one stop bit each -> three pulses, values 90, 3C, 7F in order, no loss.
REQ-021 Send 0x55 with the stop bit forced to 0, then line high -> one framing_error pulse and no ready pulse; a following 0x80 is received correctly.
REQ-022 Pull rx low for 4 cycles (shorter than HALF_BIT = 8) -> no output, and rx_busy returns to 0.
REQ-023 Send 0xF8 with FILTER_REALTIME = 1 -> no pulse, new_byte unchanged; with FILTER_REALTIME = 0 -> pulse with new_byte = F8.
REQ-024 Assert reset during DATA bit 4 of 0x3C -> no pulse and all outputs at reset values; a subsequent 0x40 is received correctly.
